// File: rtl/sha512_procb_feeder_if.sv
// Request, unit-memory and realign8_pad signals between the process_bytes
// caller and sha512_procb_feeder.
interface sha512_procb_feeder_if #(
  parameter int ADDR_MSB  = 7,
  parameter int CNT_MSB   = 7,
  parameter int TOTAL_MSB = 11
);
  logic                  init;
  logic                  start;
  logic [ADDR_MSB:0]     addr;
  logic [CNT_MSB:0]      cnt;
  logic                  fin;
  logic                  ready;
  logic                  out_full;
  logic                  mem_rd_en;
  logic [ADDR_MSB-3:0]   mem_raddr;
  logic [63:0]           mem_dout;
  logic                  wr_en;
  logic [3:0]            len;
  logic [2:0]            off;
  logic [63:0]           din;
  logic                  add0x80pad;
  logic                  add0pad;
  logic                  add_total;
  logic [TOTAL_MSB:0]    total_bytes;

  modport master (
    output init, start, addr, cnt, fin, out_full, mem_dout,
    input  ready, mem_rd_en, mem_raddr, wr_en, len, off, din,
           add0x80pad, add0pad, add_total, total_bytes
  );

  modport slave (
    input  init, start, addr, cnt, fin, out_full, mem_dout,
    output ready, mem_rd_en, mem_raddr, wr_en, len, off, din,
           add0x80pad, add0pad, add_total, total_bytes
  );
endinterface

// File: rtl/sha512_procb_feeder.sv
// Feeds realign8_pad from unit memory for process_bytes requests and appends
// SHA-512 padding (0x80, zero words, length word) up to the next 128-byte block.
//
// state | meaning
// IDLE  | ready for init / start
// DATA  | reading message words from memory
// PAD80 | emitting the 0x80 padding word
// PAD0  | emitting zero words up to the length slot
// TOTAL | emitting the total-length word
module sha512_procb_feeder #(
  parameter int ADDR_MSB  = 7,
  parameter int CNT_MSB   = 7,
  parameter int TOTAL_MSB = 11
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  sha512_procb_feeder_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PAD80,
    S_PAD0,
    S_TOTAL
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_MSB-3:0] waddr_q, waddr_d;
  logic [CNT_MSB:0]    rem_q, rem_d;
  logic                fin_q, fin_d;
  logic                first_q, first_d;
  logic [2:0]          soff_q, soff_d;
  logic [TOTAL_MSB:0]  total_q, total_d;
  logic [6:0]          bp_q, bp_d;
  logic [4:0]          zcnt_q, zcnt_d;
  logic                wr_en_q, wr_en_d;
  logic [3:0]          len_q, len_d;
  logic [2:0]          off_q, off_d;
  logic                a80_q, a80_d;
  logic                a0_q, a0_d;
  logic                at_q, at_d;
  logic                rd_en;

  logic [2:0]          off_cur;
  logic [3:0]          avail;
  logic [3:0]          len_data;
  logic [CNT_MSB:0]    len_data_ext;
  logic [3:0]          pad_len;
  logic [6:0]          bp_pad;
  logic [3:0]          w_pad;
  logic [4:0]          zfill;

  assign off_cur      = first_q ? soff_q : 3'd0;
  assign avail        = 4'd8 - {1'b0, off_cur};
  assign len_data     = (rem_q < {{(CNT_MSB-3){1'b0}}, avail}) ? rem_q[3:0] : avail;
  assign len_data_ext = {{(CNT_MSB-3){1'b0}}, len_data};

  // 0x80 word closes the current 8-byte lane; a 0x80 word landing in word 14
  // leaves no room for the length, so a full extra block of zeros follows.
  assign pad_len = 4'd8 - {1'b0, total_q[2:0]};
  assign bp_pad  = bp_q + {3'b000, pad_len};
  assign w_pad   = bp_pad[6:3];
  assign zfill   = (w_pad == 4'd15) ? 5'd16 : (5'd15 - {1'b0, w_pad});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      waddr_q <= '0;
      rem_q   <= '0;
      fin_q   <= 1'b0;
      first_q <= 1'b0;
      soff_q  <= '0;
      total_q <= '0;
      bp_q    <= '0;
      zcnt_q  <= '0;
      wr_en_q <= 1'b0;
      len_q   <= '0;
      off_q   <= '0;
      a80_q   <= 1'b0;
      a0_q    <= 1'b0;
      at_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      rem_q   <= rem_d;
      fin_q   <= fin_d;
      first_q <= first_d;
      soff_q  <= soff_d;
      total_q <= total_d;
      bp_q    <= bp_d;
      zcnt_q  <= zcnt_d;
      wr_en_q <= wr_en_d;
      len_q   <= len_d;
      off_q   <= off_d;
      a80_q   <= a80_d;
      a0_q    <= a0_d;
      at_q    <= at_d;
    end
  end

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    rem_d   = rem_q;
    fin_d   = fin_q;
    first_d = first_q;
    soff_d  = soff_q;
    total_d = total_q;
    bp_d    = bp_q;
    zcnt_d  = zcnt_q;
    wr_en_d = 1'b0;
    len_d   = 4'd0;
    off_d   = 3'd0;
    a80_d   = 1'b0;
    a0_d    = 1'b0;
    at_d    = 1'b0;
    rd_en   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.init) begin
          total_d = '0;
          bp_d    = '0;
        end else if (bus.start) begin
          waddr_d = bus.addr[ADDR_MSB:3];
          soff_d  = bus.addr[2:0];
          rem_d   = bus.cnt;
          fin_d   = bus.fin;
          first_d = 1'b1;
          if (bus.cnt != '0) begin
            state_d = S_DATA;
          end else if (bus.fin) begin
            state_d = S_PAD80;
          end
        end
      end

      S_DATA: begin
        if (!bus.out_full) begin
          rd_en   = 1'b1;
          wr_en_d = 1'b1;
          len_d   = len_data;
          off_d   = off_cur;
          waddr_d = waddr_q + 1'b1;
          rem_d   = rem_q - len_data_ext;
          total_d = total_q + {{(TOTAL_MSB-3){1'b0}}, len_data};
          bp_d    = bp_q + {3'b000, len_data};
          first_d = 1'b0;
          if (rem_q == len_data_ext) begin
            state_d = fin_q ? S_PAD80 : S_IDLE;
          end
        end
      end

      S_PAD80: begin
        if (!bus.out_full) begin
          a80_d   = 1'b1;
          a0_d    = 1'b1;
          len_d   = pad_len;
          bp_d    = bp_pad;
          zcnt_d  = zfill;
          state_d = (zfill != 5'd0) ? S_PAD0 : S_TOTAL;
        end
      end

      S_PAD0: begin
        if (!bus.out_full) begin
          a0_d   = 1'b1;
          len_d  = 4'd8;
          bp_d   = bp_q + 7'd8;
          zcnt_d = zcnt_q - 1'b1;
          if (zcnt_q <= 5'd1) begin
            state_d = S_TOTAL;
          end
        end
      end

      S_TOTAL: begin
        if (!bus.out_full) begin
          at_d    = 1'b1;
          len_d   = 4'd8;
          bp_d    = '0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ready       = (state_q == S_IDLE);
  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_raddr   = waddr_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.len         = len_q;
  assign bus.off         = off_q;
  assign bus.din         = bus.mem_dout;
  assign bus.add0x80pad  = a80_q;
  assign bus.add0pad     = a0_q;
  assign bus.add_total   = at_q;
  assign bus.total_bytes = total_q;

endmodule

// File: tb/tb_sha512_procb_feeder.sv
// Directed bench for sha512_procb_feeder: captures every emitted word and
// compares it against hand-built expected word sequences.
module tb_sha512_procb_feeder;
  localparam int ADDR_MSB  = 7;
  localparam int CNT_MSB   = 7;
  localparam int TOTAL_MSB = 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha512_procb_feeder_if #(.ADDR_MSB(ADDR_MSB), .CNT_MSB(CNT_MSB), .TOTAL_MSB(TOTAL_MSB)) bus ();

  sha512_procb_feeder #(.ADDR_MSB(ADDR_MSB), .CNT_MSB(CNT_MSB), .TOTAL_MSB(TOTAL_MSB)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    int          kind;   // 0 data, 1 pad80, 2 pad0, 3 total
    int          len;
    int          off;
    logic [63:0] din;
    int          tot;
  } ent_t;

  ent_t cap_q[$];
  ent_t exp_q[$];
  int   rd_q[$];
  int   viol = 0;
  logic of_prev = 1'b0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [63:0] memword(input logic [4:0] a);
    return {32'hC0DE_0000 | {27'd0, a}, 32'h1234_5600 | {27'd0, a}};
  endfunction

  always @(posedge clk)
    bus.mem_dout <= bus.mem_rd_en ? memword(bus.mem_raddr) : 64'hDEAD_BEEF_DEAD_BEEF;

  // Capture emitted words; count protocol violations (stall leaks, mixed strobes)
  always @(negedge clk) begin
    ent_t e;
    if (!rst) begin
      if (bus.mem_rd_en) rd_q.push_back(int'(bus.mem_raddr));
      if (bus.mem_rd_en && bus.out_full) viol++;
      if (bus.wr_en || bus.add0x80pad || bus.add0pad || bus.add_total) begin
        if (of_prev) viol++;
        if (bus.wr_en && (bus.add0x80pad || bus.add0pad || bus.add_total)) viol++;
        if (bus.add0x80pad && !bus.add0pad) viol++;
        if (bus.add_total && (bus.add0pad || bus.add0x80pad)) viol++;
        e.kind = bus.wr_en ? 0 : bus.add0x80pad ? 1 : bus.add_total ? 3 : 2;
        e.len  = int'(bus.len);
        e.off  = int'(bus.off);
        e.din  = bus.wr_en ? bus.din : 64'd0;
        e.tot  = bus.add_total ? int'(bus.total_bytes) : 0;
        cap_q.push_back(e);
      end
    end
    of_prev = bus.out_full;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    cap_q.delete();
    exp_q.delete();
    rd_q.delete();
    viol = 0;
  endtask

  task automatic push_exp(input int kind, input int len, input int off, input logic [63:0] din, input int tot);
    ent_t e;
    e.kind = kind; e.len = len; e.off = off; e.din = din; e.tot = tot;
    exp_q.push_back(e);
  endtask

  task automatic do_init();
    bus.init = 1'b1;
    cyc();
    bus.init = 1'b0;
  endtask

  task automatic req(input logic [7:0] a, input logic [7:0] c, input logic f);
    bus.addr  = a;
    bus.cnt   = c;
    bus.fin   = f;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (bus.ready && !bus.wr_en && !bus.add0x80pad && !bus.add0pad && !bus.add_total) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout ready=%0b after 400 cycles, want ready=1", name, bus.ready);
    end
  endtask

  // Scenario 1 expected stream: two aligned data words, 0x80, 12 zeros, total 16.
  task automatic exp_aligned16();
    push_exp(0, 8, 0, memword(5'd0), 0);
    push_exp(0, 8, 0, memword(5'd1), 0);
    push_exp(1, 8, 0, 64'd0, 0);
    for (int i = 0; i < 12; i++) push_exp(2, 8, 0, 64'd0, 0);
    push_exp(3, 8, 0, 64'd0, 16);
  endtask

  task automatic test_reset();
    checks++;
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b want 1", bus.ready); end
    checks++;
    if ({bus.mem_rd_en, bus.wr_en, bus.add0x80pad, bus.add0pad, bus.add_total} !== 5'b0) begin
      errors++;
      $display("FAIL rst_strobes got %b want 00000",
               {bus.mem_rd_en, bus.wr_en, bus.add0x80pad, bus.add0pad, bus.add_total});
    end
    checks++;
    if ({bus.len, bus.off} !== 7'd0) begin errors++; $display("FAIL rst_len_off got len=%0d off=%0d want 0 0", bus.len, bus.off); end
    checks++;
    if (bus.total_bytes !== 12'd0) begin errors++; $display("FAIL rst_total got %0d want 0", bus.total_bytes); end
  endtask

  task automatic test_aligned();
    clear_logs();
    do_init();
    req(8'd0, 8'd16, 1'b1);
    wait_idle("aligned");
    exp_aligned16();
    checks++;
    if (cap_q.size() !== exp_q.size()) begin errors++; $display("FAIL aligned_count got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL aligned_w%0d got k%0d l%0d o%0d d%h t%0d want k%0d l%0d o%0d d%h t%0d", i,
                 cap_q[i].kind, cap_q[i].len, cap_q[i].off, cap_q[i].din, cap_q[i].tot,
                 exp_q[i].kind, exp_q[i].len, exp_q[i].off, exp_q[i].din, exp_q[i].tot);
      end
    end
    checks++;
    if (rd_q.size() !== 2 || rd_q[0] !== 0 || rd_q[1] !== 1) begin
      errors++; $display("FAIL aligned_rdaddr got %0d reads want 2 reads at 0,1", rd_q.size());
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL aligned_protocol got %0d violations want 0", viol); end
  endtask

  task automatic test_unaligned();
    clear_logs();
    do_init();
    req(8'd5, 8'd10, 1'b1);
    wait_idle("unaligned");
    push_exp(0, 3, 5, memword(5'd0), 0);
    push_exp(0, 7, 0, memword(5'd1), 0);
    push_exp(1, 6, 0, 64'd0, 0);
    for (int i = 0; i < 13; i++) push_exp(2, 8, 0, 64'd0, 0);
    push_exp(3, 8, 0, 64'd0, 10);
    checks++;
    if (cap_q.size() !== exp_q.size()) begin errors++; $display("FAIL unal_count got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL unal_w%0d got k%0d l%0d o%0d d%h t%0d want k%0d l%0d o%0d d%h t%0d", i,
                 cap_q[i].kind, cap_q[i].len, cap_q[i].off, cap_q[i].din, cap_q[i].tot,
                 exp_q[i].kind, exp_q[i].len, exp_q[i].off, exp_q[i].din, exp_q[i].tot);
      end
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL unal_protocol got %0d violations want 0", viol); end
  endtask

  // cnt=112: 0x80 lands in word 14, forcing a full extra block of zeros.
  task automatic test_block_spill();
    clear_logs();
    do_init();
    req(8'd0, 8'd112, 1'b1);
    wait_idle("spill");
    for (int i = 0; i < 14; i++) push_exp(0, 8, 0, memword(5'(i)), 0);
    push_exp(1, 8, 0, 64'd0, 0);
    for (int i = 0; i < 16; i++) push_exp(2, 8, 0, 64'd0, 0);
    push_exp(3, 8, 0, 64'd0, 112);
    checks++;
    if (cap_q.size() !== 32) begin errors++; $display("FAIL spill_count got %0d want 32", cap_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL spill_w%0d got k%0d l%0d o%0d t%0d want k%0d l%0d o%0d t%0d", i,
                 cap_q[i].kind, cap_q[i].len, cap_q[i].off, cap_q[i].tot,
                 exp_q[i].kind, exp_q[i].len, exp_q[i].off, exp_q[i].tot);
      end
    end
  endtask

  task automatic test_boundary();
    for (int c = 0; c < 2; c++) begin
      int n = (c == 0) ? 104 : 111;
      clear_logs();
      do_init();
      req(8'd0, 8'(n), 1'b1);
      wait_idle("boundary");
      for (int i = 0; i < 13; i++) push_exp(0, 8, 0, memword(5'(i)), 0);
      if (c == 1) push_exp(0, 7, 0, memword(5'd13), 0);
      push_exp(1, (c == 0) ? 8 : 1, 0, 64'd0, 0);
      push_exp(2, 8, 0, 64'd0, 0);
      push_exp(3, 8, 0, 64'd0, n);
      checks++;
      if (cap_q.size() !== exp_q.size()) begin errors++; $display("FAIL bnd%0d_count got %0d want %0d", n, cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
        checks++;
        if (cap_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL bnd%0d_w%0d got k%0d l%0d o%0d t%0d want k%0d l%0d o%0d t%0d", n, i,
                   cap_q[i].kind, cap_q[i].len, cap_q[i].off, cap_q[i].tot,
                   exp_q[i].kind, exp_q[i].len, exp_q[i].off, exp_q[i].tot);
        end
      end
    end
  endtask

  task automatic test_resume();
    clear_logs();
    do_init();
    req(8'd0, 8'd8, 1'b0);
    wait_idle("resume1");
    checks++;
    if (bus.ready !== 1'b1 || bus.total_bytes !== 12'd8) begin
      errors++; $display("FAIL resume_mid got ready=%0b total=%0d want ready=1 total=8", bus.ready, bus.total_bytes);
    end
    req(8'd8, 8'd8, 1'b1);
    wait_idle("resume2");
    exp_aligned16();
    checks++;
    if (cap_q.size() !== exp_q.size()) begin errors++; $display("FAIL resume_count got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL resume_w%0d got k%0d l%0d o%0d d%h t%0d want k%0d l%0d o%0d d%h t%0d", i,
                 cap_q[i].kind, cap_q[i].len, cap_q[i].off, cap_q[i].din, cap_q[i].tot,
                 exp_q[i].kind, exp_q[i].len, exp_q[i].off, exp_q[i].din, exp_q[i].tot);
      end
    end
    checks++;
    if (bus.total_bytes !== 12'd16) begin errors++; $display("FAIL resume_total got %0d want 16", bus.total_bytes); end

    // cnt=0 without fin: nothing happens, ready stays high
    clear_logs();
    req(8'd0, 8'd0, 1'b0);
    checks++;
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL empty_ready got %0b want 1", bus.ready); end
    repeat (4) cyc();
    checks++;
    if (cap_q.size() !== 0 || rd_q.size() !== 0) begin
      errors++; $display("FAIL empty_output got %0d words %0d reads want 0 0", cap_q.size(), rd_q.size());
    end

    // cnt=0 with fin and T=16 kept: pad-only block, 14 zero words
    clear_logs();
    req(8'd0, 8'd0, 1'b1);
    wait_idle("padonly");
    push_exp(1, 8, 0, 64'd0, 0);
    for (int i = 0; i < 14; i++) push_exp(2, 8, 0, 64'd0, 0);
    push_exp(3, 8, 0, 64'd0, 16);
    checks++;
    if (cap_q.size() !== exp_q.size()) begin errors++; $display("FAIL padonly_count got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL padonly_w%0d got k%0d l%0d t%0d want k%0d l%0d t%0d", i,
                 cap_q[i].kind, cap_q[i].len, cap_q[i].tot, exp_q[i].kind, exp_q[i].len, exp_q[i].tot);
      end
    end
  endtask

  task automatic test_stall();
    int stall_cycles = 0;
    clear_logs();
    do_init();
    req(8'd0, 8'd16, 1'b1);
    cyc();
    bus.out_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (bus.ready === 1'b0) stall_cycles++;
    end
    bus.out_full = 1'b0;
    repeat (5) cyc();
    bus.out_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (bus.ready === 1'b0) stall_cycles++;
    end
    bus.out_full = 1'b0;
    wait_idle("stall");
    exp_aligned16();
    checks++;
    if (cap_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_count got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL stall_w%0d got k%0d l%0d o%0d d%h t%0d want k%0d l%0d o%0d d%h t%0d", i,
                 cap_q[i].kind, cap_q[i].len, cap_q[i].off, cap_q[i].din, cap_q[i].tot,
                 exp_q[i].kind, exp_q[i].len, exp_q[i].off, exp_q[i].din, exp_q[i].tot);
      end
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL stall_protocol got %0d violations want 0", viol); end
    checks++;
    if (stall_cycles !== 6) begin errors++; $display("FAIL stall_busy got %0d busy stall cycles want 6", stall_cycles); end
    checks++;
    if (rd_q.size() !== 2) begin errors++; $display("FAIL stall_reads got %0d want 2", rd_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    clear_logs();
    do_init();
    req(8'd0, 8'd16, 1'b1);
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (bus.add0pad && !bus.add0x80pad) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rstmid_reach got no PAD0 word want PAD0 within 50 cycles"); end
    rst = 1'b1;
    cyc();
    checks++;
    if ({bus.ready, bus.mem_rd_en, bus.wr_en, bus.add0x80pad, bus.add0pad, bus.add_total} !== 6'b100000) begin
      errors++;
      $display("FAIL rstmid_strobes got %b want 100000",
               {bus.ready, bus.mem_rd_en, bus.wr_en, bus.add0x80pad, bus.add0pad, bus.add_total});
    end
    checks++;
    if (bus.len !== 4'd0 || bus.total_bytes !== 12'd0) begin
      errors++; $display("FAIL rstmid_vals got len=%0d total=%0d want 0 0", bus.len, bus.total_bytes);
    end
    rst = 1'b0;
    clear_logs();
    repeat (20) cyc();
    checks++;
    if (cap_q.size() !== 0 || rd_q.size() !== 0 || bus.ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_quiet got %0d words %0d reads ready=%0b want 0 0 1", cap_q.size(), rd_q.size(), bus.ready);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.init     = 1'b0;
    bus.start    = 1'b0;
    bus.addr     = '0;
    bus.cnt      = '0;
    bus.fin      = 1'b0;
    bus.out_full = 1'b0;
    repeat (3) cyc();
    test_reset();
    rst = 1'b0;
    cyc();
    test_aligned();
    test_unaligned();
    test_block_spill();
    test_boundary();
    test_resume();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha512_procb_feeder.md
Name: sha512_procb_feeder

Overview:
- Upstream feeder for the realign8_pad stage; one instance per sha512unit.
- Accepts process_bytes requests of the form {byte address, byte count, finish}. It reads the 64-bit words from unit memory and drives realign8_pad's wr_en/len/off/din.
- On finish it emits the SHA512 padding sequence: 0x80 word, zero words, total-length word. The next 128-byte block boundary is reached exactly.
- It keeps the running total across resumed requests until `init`.

Parameters:
- ADDR_MSB, 7: MSB of byte address; word address is addr[ADDR_MSB:3].
- CNT_MSB, 7: MSB of request byte count.
- TOTAL_MSB, 11: MSB of running total byte counter; equals `PROCB_TOTAL_MSB in sha512unit.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- init  in  1  clear running total and block byte position; accepted only when ready.
- start  in  1  request strobe; accepted when start & ready.
- addr  in  ADDR_MSB+1  request start byte address.
- cnt  in  CNT_MSB+1  request byte count; 0 allowed.
- fin  in  1  append padding and length after this request's data.
- ready  out  1  high in IDLE.
- out_full  in  1  downstream cannot take a word this cycle; stalls issue.
- mem_rd_en  out  1  memory read strobe; 1-cycle read latency.
- mem_raddr  out  ADDR_MSB-2  word address.
- mem_dout  in  64  memory read data.
- wr_en  out  1  to realign8_pad.
- len  out  4  1..8.
- off  out  3  byte offset.
- din  out  64  equals mem_dout (combinational pass-through).
- add0x80pad, add0pad, add_total  out  1 each  to realign8_pad.
- total_bytes  out  TOTAL_MSB+1  running total T.

Behaviour:
- Reset values:
  - ready=1; state IDLE.
  - mem_rd_en, wr_en, add0x80pad, add0pad and add_total are all 0.
  - len=0, off=0, T=0, block byte position bp=0.
- States: IDLE, DATA, PAD80, PAD0, TOTAL.
- IDLE: init clears T and bp; init wins over start when both are high.
- IDLE on start:
  - Latch addr, cnt and fin.
  - cnt>0 → DATA.
  - cnt==0 & fin → PAD80.
  - cnt==0 & ~fin → stay IDLE; ready stays 1; no output.
- DATA, each cycle with ~out_full:
  - Issue mem_rd_en at the current word address.
  - First word: off=addr[2:0], len=min(8-off, remaining).
  - Later words: off=0, len=min(8, remaining).
  - Advance word address; subtract len from remaining; add len to T and to bp (mod 128).
  - remaining reaches 0 → PAD80 if fin, else IDLE.
- DATA with out_full high: no rd_en; address, remaining and state hold.
- Output timing:
  - wr_en, len and off are registered; they assert exactly one cycle after their mem_rd_en, aligned with mem_dout.
  - The pad controls are registered on the same one-cycle schedule.
  - wr_en is never asserted together with any pad control.
- PAD80, P=T mod 8:
  - One cycle with ~out_full: add0x80pad=1, add0pad=1, len=8-P (1..8).
  - bp += 8-P, so bp is now 8-aligned.
  - w = bp[6:3]; Z = (w==15) ? 16 : 15-w. A 0x80 word in word 14 forces a full extra block.
  - Z>0 → PAD0, else TOTAL (cannot occur per the formula; Z≥1).
- PAD0: Z cycles (not counting out_full stalls), each with add0pad=1 and len=8; bp += 8 each.
- TOTAL:
  - One cycle: add_total=1, len=8, total_bytes=T; bp becomes 0.
  - Then → IDLE. T is kept until init.
- Stalls: out_full stalls PAD80, PAD0 and TOTAL identically; nothing is issued and the count holds.
- The realign8_pad rule that only the first word of a block may be unaligned is the caller's responsibility. A resumed request with addr[2:0]≠0 after a non-8-aligned T is not checked here.
- Width rules:
  - T wraps mod 2^(TOTAL_MSB+1); no flag.
  - Remaining, Z and bp use exact widths.
  - 8-off is computed in 4 bits.
- Reset mid-operation: next cycle all outputs are at reset values and state is IDLE. In-flight delayed wr_en and pad controls are cancelled.
- ready is 0 from the accept cycle until the cycle after the last issue.

Test Plan:
- init; start addr=0 cnt=16 fin=1:
  - Data: rd 0,1; wr_en len 8,8 off 0.
  - PAD80 len 8.
  - 12×add0pad.
  - add_total with total_bytes=16.
  - 16 words total.
- init; addr=5 cnt=10 fin=1:
  - Data: rd 0,1; (off5,len3), (off0,len7).
  - PAD80 len=6.
  - 13 zero words; total_bytes=10.
- init; addr=0 cnt=112 fin=1:
  - Data: 14 data words.
  - PAD80 len 8 at word 14.
  - 16 zero words; total word.
  - 32 words total.
- init; cnt=104 fin=1 → 13 data, PAD80, 1 zero, total (16 words). Second case: cnt=111 → PAD80 len=1, 1 zero, total.
- init; cnt=8 fin=0, then cnt=8 fin=1 → output identical to the first scenario; ready=1 between requests; T=16.
- out_full held 3 cycles mid-DATA and mid-PAD0 → no rd_en/pad pulses while high; word sequence is unchanged.
- RESET asserted mid-PAD0 → next cycle all outputs 0 and ready=1.
